// File: rtl/hamming_inj_pkg.sv
// Shared types and constants for the Hamming codec fault injector.
package hamming_inj_pkg;

    localparam int unsigned CW_WIDTH = 21;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned INJ_IDX_W = 5;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_WALK1 = 2'd1,
        MODE_RAND1 = 2'd2,
        MODE_WALK2 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0 when adv is high.
module lfsr16
    import hamming_inj_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/hamming_fault_injector.sv
// Burst generator of bit_flip error vectors (none / walking-1 / random-1 / walking-2)
// XORed onto the codeword between Hamming coder and decoder.
module hamming_fault_injector
    import hamming_inj_pkg::*;
#(
    parameter int unsigned       WIDTH     = CW_WIDTH,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_W-1:0]     count,
    output logic [WIDTH-1:0]     bit_flip,
    output logic [INJ_IDX_W-1:0] inj_index,
    output logic                 busy,
    output logic                 done
);

    localparam logic [INJ_IDX_W-1:0] IDX_LAST = INJ_IDX_W'(WIDTH - 1);
    localparam logic [INJ_IDX_W-1:0] IDX_MOD  = INJ_IDX_W'(WIDTH);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [INJ_IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]       bit_flip_q, bit_flip_d;
    logic [INJ_IDX_W-1:0]   inj_index_q, inj_index_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   lfsr_adv_c;
    logic [LFSR_W-1:0]      lfsr_q;
    logic [INJ_IDX_W-1:0]   lfsr_r_c;
    logic [INJ_IDX_W-1:0]   rand_idx_c;
    logic [INJ_IDX_W-1:0]   idx_next_c;
    logic                   lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv_c),
        .q     (lfsr_q)
    );

    // Only the low five LFSR bits pick the random index
    assign lfsr_r_c    = lfsr_q[INJ_IDX_W-1:0];
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:INJ_IDX_W];
    assign rand_idx_c  = (lfsr_r_c < IDX_MOD) ? lfsr_r_c : (lfsr_r_c - IDX_MOD);
    assign idx_next_c  = (idx_q == IDX_LAST) ? '0 : (idx_q + INJ_IDX_W'(1));
    assign lfsr_adv_c  = (state_q == ST_RUN);

    // Next-state and next-output logic; outputs describe the cycle after the edge
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        bit_flip_d  = '0;
        inj_index_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode_e'(mode);
                    remaining_d = count;
                    idx_d       = '0;
                    state_d     = (count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy_d      = 1'b1;
                idx_d       = idx_next_c;
                remaining_d = (remaining_q != '0) ? (remaining_q - CNT_W'(1)) : '0;
                if (remaining_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
                case (mode_q)
                    MODE_WALK1: begin
                        bit_flip_d  = WIDTH'(1) << idx_q;
                        inj_index_d = idx_q;
                    end
                    MODE_RAND1: begin
                        bit_flip_d  = WIDTH'(1) << rand_idx_c;
                        inj_index_d = rand_idx_c;
                    end
                    MODE_WALK2: begin
                        bit_flip_d  = (WIDTH'(1) << idx_q) | (WIDTH'(1) << idx_next_c);
                        inj_index_d = idx_q;
                    end
                    default: begin
                        bit_flip_d  = '0;
                        inj_index_d = '0;
                    end
                endcase
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NONE;
            remaining_q <= '0;
            idx_q       <= '0;
            bit_flip_q  <= '0;
            inj_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            bit_flip_q  <= bit_flip_d;
            inj_index_q <= inj_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bit_flip  = bit_flip_q;
    assign inj_index = inj_index_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/hamming_fault_injector.md
Name: hamming_fault_injector

Overview:
- Upstream stimulus stage for the Hamming Codec. Generates the 21-bit bit_flip vector that is XORed onto the coded word between Coder and Decoder.
- Produces a programmable burst of error patterns, one vector per clock: none, walking single-bit, pseudo-random single-bit, or walking adjacent double-bit.
- Used for correction-coverage runs and power-evaluation runs. It provides deterministic, repeatable error sequences.

Parameters:
- WIDTH, 21, codeword width (equals bit_flip width).
- CNT_W, 16, width of the burst-length counter.
- LFSR_SEED, 16'hACE1, reset value of the random-index LFSR; must be non-zero.

Ports:
- clk  input  1  rising-edge clock, shared with Codec.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
- mode  input  2  pattern select, latched on accepted start: 0 NONE, 1 WALK1, 2 RAND1, 3 WALK2.
- count  input  CNT_W  number of vectors in the burst, latched on accepted start.
- bit_flip  output  WIDTH  registered error vector to Codec.
- inj_index  output  5  registered index of the (first) flipped bit in the current vector; 0 when no flip.
- busy  output  1  high while the burst is running.
- done  output  1  one-cycle pulse after the last vector.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; bit_flip=0, inj_index=0, busy=0, done=0; remaining=0; walk index=0; LFSR=LFSR_SEED.
- States:
  - IDLE -> RUN on start when count!=0.
  - IDLE -> DONE on start when count==0.
  - RUN -> DONE when the vector with remaining==1 is issued.
  - DONE -> IDLE unconditionally after one cycle.
- Accepted start: latch mode and count; clear the walk index to 0. The LFSR is NOT reseeded.
- start while busy or in DONE: ignored, with no effect on the latched values.
- Timing, with start sampled at edge t:
  - Vector k (k=0..count-1) is visible on bit_flip during the cycle after edge t+1+k.
  - busy is high over the same cycles.
  - done is high for exactly one cycle after edge t+1+count.
  - bit_flip=0 in IDLE and DONE.
- count==0: no vectors are issued; busy stays 0; done pulses one cycle after the start edge.
- Per-vector patterns in RUN (idx is the walk index):
  - NONE: bit_flip=0, inj_index=0. The vector still counts toward the burst.
  - WALK1: bit_flip=1<<idx, inj_index=idx; idx advances 0..20 and wraps 20->0.
  - RAND1: r=lfsr[4:0]; index = r if r<21, else r-21. bit_flip=1<<index, inj_index=index.
  - WALK2: bits idx and (idx+1) mod 21 are set, inj_index=idx. At idx=20 the vector is bits 20 and 0. idx wraps as in WALK1.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0.
  - Advances once per RUN cycle in every mode; holds in IDLE/DONE.
  - The sequence continues across bursts; only reset restores LFSR_SEED.
- Counter: remaining loads count on start and decrements once per issued vector. It never underflows.
- Reset mid-burst: all outputs go to zero immediately; no done pulse is produced; the next burst requires a new start.
- X-safety: mode and count are don't-care except on the accepted-start cycle.

Decomposition:
- Package hamming_inj_pkg holds:
  - mode enum (MODE_NONE, MODE_WALK1, MODE_RAND1, MODE_WALK2);
  - state enum (ST_IDLE, ST_RUN, ST_DONE);
  - CW_WIDTH=21;
  - LFSR tap mask constant;
  - default seed.
- One sub-module, lfsr16 (ports: clk, rst_n, adv, q[15:0], seed parameter), is reused by bench stimulus generators.
- Mod-21 wrap and pattern generation stay inline in hamming_fault_injector.

Test Plan:
- Reset, then mode=1, count=21, start -> bit_flip = 0x000001, 0x000002, ... 0x100000 on consecutive cycles; inj_index 0..20; busy high for 21 cycles; done pulses once; then bit_flip=0.
- mode=3, count=22 -> vectors 0x000003 ... 0x180000, then 0x100001 (idx 20), then 0x000003. Through Codec, the decoded data differs from the input (uncorrectable double error, reported to the checker).
- After reset, mode=2, count=8 -> each vector is one-hot with inj_index<21, and the sequence matches the reference model from seed 0xACE1. A second burst continues the sequence without repeating the first 8 vectors.
- count=0 start -> busy never asserts, bit_flip stays 0, done high exactly one cycle after the start edge.
- Assert rst_n=0 at the 5th vector of a WALK1 burst of 10 -> bit_flip/busy go to 0 asynchronously, no done. A new start of mode=1 restarts at 0x000001.
- start pulsed again mid-burst with a different mode/count -> ignored; the original burst length and pattern complete unchanged.
